// File: rtl/zeus_irq_pkg.sv
// Shared constants for the Zeus IRQ sequencer: register map, source count, bus FSM states.
// Latency: n/a; backpressure: n/a.
package zeus_irq_pkg;
  localparam int IRQ_COUNT     = 8;
  localparam int VEC_VALID_BIT = 7;

  localparam logic [2:0] ADDR_PEND   = 3'd0;
  localparam logic [2:0] ADDR_ENABLE = 3'd1;
  localparam logic [2:0] ADDR_MODE   = 3'd2;
  localparam logic [2:0] ADDR_VECTOR = 3'd3;
  localparam logic [2:0] ADDR_ISR    = 3'd4;

  typedef enum logic {
    BUS_IDLE  = 1'b0,
    BUS_ARMED = 1'b1
  } bus_state_e;
endpackage

// File: rtl/irq_priority_encoder.sv
// Fixed-priority encoder: reports whether any bit is set and the lowest set index.
// Latency: combinational; backpressure: none.
module irq_priority_encoder
  import zeus_irq_pkg::*;
(
  input  logic [IRQ_COUNT-1:0] req,
  output logic                 found,
  output logic [2:0]           idx
);
  always_comb begin
    found = 1'b0;
    idx   = 3'd0;
    for (int i = IRQ_COUNT - 1; i >= 0; i--) begin
      if (req[i]) begin
        found = 1'b1;
        idx   = 3'(i);
      end
    end
  end
endmodule

// File: rtl/irq_priority_sequencer.sv
// Nesting fixed-priority interrupt sequencer: synchronised edge/level sources, VECTOR ack, EOI.
// Latency: level source to irq_out_n = SYNC_STAGES+1 clk; edge one more; no backpressure, one commit per bus cycle.
module irq_priority_sequencer
  import zeus_irq_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       cs_n,
  input  logic       phi2,
  input  logic       write_enable,
  input  logic [2:0] address,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  input  logic [7:0] irq_sources_n,
  output logic       irq_out_n
);
  logic [SYNC_STAGES-1:0][IRQ_COUNT-1:0] sync_q, sync_d;
  logic [IRQ_COUNT-1:0] prev_n_q, prev_n_d;
  logic [IRQ_COUNT-1:0] latch_q, latch_d;
  logic [IRQ_COUNT-1:0] enable_q, enable_d;
  logic [IRQ_COUNT-1:0] mode_q, mode_d;
  logic [IRQ_COUNT-1:0] isr_q, isr_d;
  logic                 phi2_q, phi2_d;
  bus_state_e           state_q, state_d;
  logic                 irq_out_n_q, irq_out_n_d;

  logic [IRQ_COUNT-1:0] sync_n, pend_eff, fell, below_isr, qual, latch_clr;
  logic [7:0]           vector_val;
  logic                 isr_found, req_found, commit;
  logic [2:0]           isr_idx, req_idx;

  assign sync_n   = sync_q[SYNC_STAGES-1];
  assign pend_eff = (mode_q & latch_q) | (~mode_q & ~sync_n);
  assign fell     = prev_n_q & ~sync_n;

  irq_priority_encoder u_isr_enc (
    .req   (isr_q),
    .found (isr_found),
    .idx   (isr_idx)
  );

  // Only sources strictly above the most urgent in-service level may interrupt.
  assign below_isr = isr_found ? ((8'd1 << isr_idx) - 8'd1) : 8'hFF;
  assign qual      = enable_q & pend_eff & below_isr;

  irq_priority_encoder u_req_enc (
    .req   (qual),
    .found (req_found),
    .idx   (req_idx)
  );

  always_comb begin
    vector_val = 8'h00;
    if (req_found) begin
      vector_val[VEC_VALID_BIT] = 1'b1;
      vector_val[2:0]           = req_idx;
    end
  end

  always_comb begin
    state_d = state_q;
    commit  = 1'b0;
    case (state_q)
      BUS_IDLE: begin
        if (!cs_n && phi2) state_d = BUS_ARMED;
      end
      BUS_ARMED: begin
        if (cs_n) begin
          state_d = BUS_IDLE;
        end else if (phi2_q && !phi2) begin
          commit  = 1'b1;
          state_d = BUS_IDLE;
        end
      end
      default: state_d = BUS_IDLE;
    endcase
  end

  always_comb begin
    enable_d  = enable_q;
    mode_d    = mode_q;
    isr_d     = isr_q;
    latch_clr = '0;
    if (commit) begin
      case (address)
        ADDR_PEND:   if (write_enable) latch_clr = data_in;
        ADDR_ENABLE: if (write_enable) enable_d = data_in;
        ADDR_MODE:   if (write_enable) mode_d = data_in;
        ADDR_VECTOR: begin
          if (!write_enable && req_found) begin
            isr_d     = isr_q | (8'd1 << req_idx);
            latch_clr = 8'd1 << req_idx;
          end
        end
        ADDR_ISR: begin
          if (write_enable && isr_found) isr_d = isr_q & ~(8'd1 << isr_idx);
        end
        default: ;
      endcase
    end
    // A fresh edge in the same clk as a clear keeps the bit pending.
    latch_d     = (latch_q & ~latch_clr) | (fell & mode_q);
    sync_d      = {sync_q[SYNC_STAGES-2:0], irq_sources_n};
    prev_n_d    = sync_n;
    phi2_d      = phi2;
    irq_out_n_d = ~req_found;
  end

  always_comb begin
    data_out = 8'h00;
    case (address)
      ADDR_PEND:   data_out = pend_eff;
      ADDR_ENABLE: data_out = enable_q;
      ADDR_MODE:   data_out = mode_q;
      ADDR_VECTOR: data_out = vector_val;
      ADDR_ISR:    data_out = isr_q;
      default:     data_out = 8'h00;
    endcase
  end

  assign irq_out_n = irq_out_n_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync_q      <= '1;
      prev_n_q    <= '1;
      latch_q     <= '0;
      enable_q    <= '0;
      mode_q      <= '0;
      isr_q       <= '0;
      phi2_q      <= 1'b0;
      state_q     <= BUS_IDLE;
      irq_out_n_q <= 1'b1;
    end else begin
      sync_q      <= sync_d;
      prev_n_q    <= prev_n_d;
      latch_q     <= latch_d;
      enable_q    <= enable_d;
      mode_q      <= mode_d;
      isr_q       <= isr_d;
      phi2_q      <= phi2_d;
      state_q     <= state_d;
      irq_out_n_q <= irq_out_n_d;
    end
  end
endmodule

// File: doc/irq_priority_sequencer.md
# irq_priority_sequencer

Prioritised, nesting interrupt sequencer for the Zeus peripheral bus. It replaces flat mask-and-OR IRQ merging. It synchronises eight active-low sources and latches edge- or level-mode requests. It arbitrates by fixed priority, presents a vector on a read-acknowledge, and tracks in-service levels until software writes End-Of-Interrupt, driving a single active-low IRQ to the CPU.

## Interface
- SYNC_STAGES, 2, synchroniser depth on irq_sources_n (min 2)
- clk  in  1  system clock
- reset_n  in  1  one clock; reset is synchronous and active-low
- cs_n  in  1  chip select, active low
- phi2  in  1  bus clock, sampled in clk domain
- write_enable  in  1  1 = bus write cycle
- address  in  3  register select
- data_in  in  8  write data
- data_out  out  8  read data (combinational from registers)
- irq_sources_n  in  8  request inputs, active low, asynchronous
- irq_out_n  out  1  registered IRQ to CPU, active low

## Operation
- Priority: index 0 highest, 7 lowest; fixed.
- Registers (address):
  - 0 PEND: R = effective pending; W1C clears edge-latched bits; no effect on level-mode bits.
  - 1 ENABLE: RW, mask.
  - 2 MODE: RW, 1 = edge (falling), 0 = level.
  - 3 VECTOR: R = acknowledge. Returns {1'b1, 4'b0, idx[2:0]} of highest-priority enabled pending source above the current in-service level. On commit it sets ISR[idx] and clears edge latch[idx]. If none qualifies, returns 8'h00 with no state change.
  - 4 ISR: R = in-service; any write = EOI, clears highest-priority set ISR bit; EOI with ISR = 0 is no-op.
  - 5–7: read 8'h00, writes ignored.
- Effective pending: `level ? ~sync_n : edge_latch`.
- Edge detector runs always. The latch sets only when MODE bit = 1.
- Qualifying request: enabled, pending, and index strictly lower than the lowest set ISR index. All eight qualify when ISR = 0.
- irq_out_n is registered low iff a qualifying request exists.
- Bus FSM:
  - IDLE: wait for cs_n low with phi2 high, go to ARMED.
  - ARMED: on phi2 falling (phi2_q = 1, phi2 = 0), produce a one-clk commit strobe and return to IDLE. If cs_n rises first, return to IDLE with no commit.
  - All writes and read side effects occur only on the commit strobe, exactly once per bus cycle.
  - data_out reflects address continuously; the VECTOR value is not frozen.
- Reset values: ENABLE = MODE = PEND latches = ISR = 0; synchroniser flops = 1; phi2_q = 0; FSM = IDLE; irq_out_n = 1; data_out follows registers (8'h00 at addresses 0–4).

## Timing
- Level source: falling input sampled at clk edge N, synced at N+SYNC_STAGES-1, irq_out_n low after edge N+SYNC_STAGES.
- Edge source: latch at N+SYNC_STAGES, irq_out_n low one edge later.
- Commit effects are visible in registers the clk after the strobe. irq_out_n updates one further clk.
- Same-cycle conflicts:
  - New edge with W1C or ack on the same bit: set wins, and the bit stays pending.
  - ENABLE write and a request in the same cycle: the new ENABLE applies from the next cycle.
- Level source still asserted after ack: remains pending but blocked by its own ISR bit. It reasserts irq_out_n after EOI.
- Reset mid-bus-cycle: the access is dropped and no commit occurs.
- Sources held low through reset with MODE later set to edge: no latch, since no falling edge is detected after reset.

## Structure
- Package zeus_irq_pkg:
  - register address localparams
  - IRQ_COUNT = 8
  - VEC_VALID_BIT = 7
  - bus FSM state enum
- Sub-module irq_priority_encoder: 8-bit vector in, {found, idx[2:0]} out, lowest index wins. Used twice: qualifying-request select and lowest-ISR select.

## Test plan
- Reset, then read all registers: addresses 0–4 return 8'h00, irq_out_n = 1.
- ENABLE = 8'h0C, level, pull source 3 low: irq_out_n low at edge SYNC_STAGES+1.
  - VECTOR read returns 8'h83, ISR = 8'h08, irq_out_n stays low while level held? No: it goes high.
  - EOI with source still low: irq_out_n returns low.
- Nesting: sources 5 and 2 enabled in edge mode, pulse 5.
  - Ack returns 8'h85. Pulse 2: irq_out_n low, ack returns 8'h82, ISR = 8'h24.
  - EOI gives ISR = 8'h20; second EOI gives 8'h00.
- Priority block: ISR[1] set, source 4 pending and enabled: irq_out_n = 1, and a VECTOR read returns 8'h00 with ISR unchanged.
- Edge W1C race: W1C PEND bit 6 commits in the same clk as a new synced falling edge on 6: PEND[6] remains 1.
- Single commit: hold cs_n low with address 3 over phi2 high for 10 clks: exactly one ack, ISR gains one bit. A cs_n abort before phi2 falls causes no change.
